des_round_ctrl: RTL and testbench
=================================

// Module: des_round_ctrl
// PURPOSE
//  Sequencer for the iterative DES core: one Feistel round per clock through the shared S1..S8 f-function datapath.
//  Accepts a start request, drives load/round/final strobes plus round index and key-rotation controls
//  to the L/R registers and C/D key registers, and reports completion. It holds no data, only control.
// PARAMETERS
//  ROUNDS      16  rounds per block; legal 1..16 (values <16 only for reduced-round debug)
//  DONE_PULSE  1   1: done is a 1-cycle pulse; 0: done holds high until the next accepted start
// PORTS
//  clk        in   1  clock, rising edge
//  rst        in   1  asynchronous reset, active high
//  start      in   1  request a block; sampled only while ready=1
//  decrypt    in   1  0=encrypt, 1=decrypt; captured with start
//  ready      out  1  high in IDLE (and DONE when DONE_PULSE=0)
//  busy       out  1  high from LOAD through FINAL
//  load_ip    out  1  datapath: load IP(plaintext) into L0/R0; key: load PC1(key) into C/D
//  round_en   out  1  datapath: L<=R, R<=L^f(R,K) this cycle
//  round_idx  out  4  current round, 0..ROUNDS-1 (valid while round_en=1)
//  key_rot    out  2  C/D rotate amount this cycle: 0,1,2
//  key_dir    out  1  rotate direction: 0=left (enc), 1=right (dec)
//  final_en   out  1  datapath: swap L/R, apply FP, register output
//  done       out  1  output block valid
// BEHAVIOUR
//  Reset: state=IDLE; ready=1; busy,load_ip,round_en,final_en,done=0; round_idx=0; key_rot=0; key_dir=0.
//  Reset mid-block aborts immediately; no done is produced for the aborted block.
//  States: IDLE -> LOAD -> ROUND (xROUNDS) -> FINAL -> DONE -> IDLE.
//  IDLE: ready=1. start=1 at edge N captures decrypt into mode reg, next state LOAD.
//  LOAD (cycle N+1): load_ip=1, busy=1, key_rot=0.
//  ROUND (cycles N+2 .. N+1+ROUNDS): round_en=1, round_idx counts 0..ROUNDS-1, 4-bit counter,
//    exits to FINAL when round_idx==ROUNDS-1; no wrap past ROUNDS-1.
//  key_rot applies to C/D in the same cycle as round_en, so subkey K(i) uses rotated C/D:
//    encrypt (key_dir=0): round_idx 0,1,8,15 -> 1; all others -> 2 (total 28).
//    decrypt (key_dir=1): round_idx 0 -> 0; 1,8,15 -> 1; all others -> 2.
//  key_dir = captured mode throughout LOAD..FINAL; changes on decrypt input while busy are ignored.
//  FINAL (cycle N+2+ROUNDS): final_en=1, round_en=0, key_rot=0.
//  DONE (cycle N+3+ROUNDS; N+19 for ROUNDS=16): done=1, busy=0.
//    DONE_PULSE=1: DONE lasts one cycle, ready=0 in it, then IDLE; next start accepted at N+20.
//    DONE_PULSE=0: remains in DONE with done=1 and ready=1; start there behaves as in IDLE
//      (done drops at next edge, state LOAD), giving back-to-back blocks.
//  start while busy=1: ignored, not queued.
//  All strobes are registered (Moore outputs); exactly one of load_ip/round_en/final_en is high at any time or none.
//  Invalid state encodings recover to IDLE.
// TESTING
//  Reset: assert rst asynchronously mid-ROUND (round_idx=5) -> all strobes 0, ready=1 within same cycle, no done.
//  Encrypt: start=1,decrypt=0 at N -> load_ip@N+1, 16 round_en @N+2..N+17, key_rot seq 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, final_en@N+18, done@N+19.
//  Decrypt: same with decrypt=1 -> key_dir=1, key_rot seq 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; sum 27+rotation check.
//  Busy start: pulse start at N+5 and toggle decrypt -> ignored; key_dir unchanged; only one done.
//  DONE_PULSE=0: start asserted during DONE -> done falls next edge, load_ip next cycle, second block done 19 cycles later.
//  Golden: drive a DES datapath model with key 133457799BBCDFF1, pt 0123456789ABCDEF -> ct 85E813540F0AB405; decrypt returns pt.

Source files
------------

// File: rtl/des_round_ctrl.sv
// Control sequencer for an iterative DES core: one Feistel round per clock.
// Drives load/round/final strobes, round index and C/D key-rotation controls.
module des_round_ctrl #(
  parameter int ROUNDS     = 16,
  parameter bit DONE_PULSE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       decrypt,
  output logic       ready,
  output logic       busy,
  output logic       load_ip,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic [1:0] key_rot,
  output logic       key_dir,
  output logic       final_en,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] LAST = 4'(ROUNDS - 1);

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       mode_q, mode_d;
  logic       accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    accept   = 1'b0;
    ready    = 1'b0;
    busy     = 1'b0;
    load_ip  = 1'b0;
    round_en = 1'b0;
    final_en = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready  = 1'b1;
        accept = start;
      end
      S_LOAD: begin
        busy    = 1'b1;
        load_ip = 1'b1;
        idx_d   = 4'd0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        busy     = 1'b1;
        round_en = 1'b1;
        if (idx_q == LAST) state_d = S_FINAL;
        else idx_d = idx_q + 4'd1;
      end
      S_FINAL: begin
        busy     = 1'b1;
        final_en = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (DONE_PULSE) begin
          state_d = S_IDLE;
        end else begin
          ready  = 1'b1;
          accept = start;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A start in IDLE (or held DONE) latches the mode for the whole block
    if (accept) begin
      state_d = S_LOAD;
      mode_d  = decrypt;
    end
  end

  assign round_idx = round_en ? idx_q : 4'd0;
  assign key_dir   = mode_q;

  // Decrypt skips the first shift: the encrypt schedule sums to 28 (identity)
  always_comb begin
    key_rot = 2'd0;
    if (round_en) begin
      if (idx_q == 4'd0)
        key_rot = mode_q ? 2'd0 : 2'd1;
      else if (idx_q == 4'd1 || idx_q == 4'd8 || idx_q == 4'd15)
        key_rot = 2'd1;
      else
        key_rot = 2'd2;
    end
  end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Testbench for des_round_ctrl: strobe sequence model plus a DES datapath
// model driven by the controller strobes (golden vector and round trips).
module tb_des_round_ctrl;

  localparam int NU = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start [NU];
  logic       dec_i [NU];
  logic       ready [NU];
  logic       busy [NU];
  logic       load_ip [NU];
  logic       round_en [NU];
  logic [3:0] round_idx [NU];
  logic [1:0] key_rot [NU];
  logic       key_dir [NU];
  logic       final_en [NU];
  logic       done [NU];

  int checks = 0;
  int failures = 0;

  des_round_ctrl #(.ROUNDS(16), .DONE_PULSE(1'b1)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .decrypt(dec_i[0]),
    .ready(ready[0]), .busy(busy[0]), .load_ip(load_ip[0]),
    .round_en(round_en[0]), .round_idx(round_idx[0]),
    .key_rot(key_rot[0]), .key_dir(key_dir[0]),
    .final_en(final_en[0]), .done(done[0])
  );

  des_round_ctrl #(.ROUNDS(16), .DONE_PULSE(1'b0)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .decrypt(dec_i[1]),
    .ready(ready[1]), .busy(busy[1]), .load_ip(load_ip[1]),
    .round_en(round_en[1]), .round_idx(round_idx[1]),
    .key_rot(key_rot[1]), .key_dir(key_dir[1]),
    .final_en(final_en[1]), .done(done[1])
  );

  des_round_ctrl #(.ROUNDS(1), .DONE_PULSE(1'b1)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .decrypt(dec_i[2]),
    .ready(ready[2]), .busy(busy[2]), .load_ip(load_ip[2]),
    .round_en(round_en[2]), .round_idx(round_idx[2]),
    .key_rot(key_rot[2]), .key_dir(key_dir[2]),
    .final_en(final_en[2]), .done(done[2])
  );

  function automatic int rounds_of(input int u);
    return (u == 2) ? 1 : 16;
  endfunction

  function automatic bit dp_of(input int u);
    return (u != 1);
  endfunction

  // Standard DES left-shift schedule; decrypt round i undoes encrypt round 16-i
  int ENC_SHIFT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  function automatic logic [1:0] sched(input int i, input bit dec);
    if (!dec) return 2'(ENC_SHIFT[i]);
    if (i == 0) return 2'd0;
    return 2'(ENC_SHIFT[16 - i]);
  endfunction

  // ---------------- DES reference datapath ----------------
  int P_T [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                   2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,
                     10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15,7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,
                     23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,
                     44,49,39,56,34,53,46,42,50,36,29,32};
  int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,
      0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,
      15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,
      3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,
      13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,
      13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,
      1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,
      13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,
      3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,
      14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,
      11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,
      10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,
      4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,
      13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,
      6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,
      1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,
      2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  function automatic int ip_src(input int i);
    int r;
    int c;
    r = i / 8;
    c = i % 8;
    return ((r < 4) ? 58 + 2 * r : 57 + 2 * (r - 4)) - 8 * c;
  endfunction

  function automatic logic [63:0] ip_fn(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = x[64-ip_src(i)];
    return o;
  endfunction

  function automatic logic [63:0] fp_fn(input logic [63:0] y);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[64-ip_src(i)] = y[63-i];
    return o;
  endfunction

  function automatic logic [55:0] pc1_fn(input logic [63:0] k);
    logic [55:0] o;
    for (int i = 0; i < 56; i++) o[55-i] = k[64-PC1_T[i]];
    return o;
  endfunction

  function automatic logic [47:0] pc2_fn(input logic [55:0] cd);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2_T[i]];
    return o;
  endfunction

  function automatic logic [31:0] f_fn(input logic [31:0] r,
                                       input logic [47:0] k);
    logic [47:0] e;
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] o;
    logic [5:0]  six;
    int          idx;
    for (int i = 0; i < 48; i++)
      e[47-i] = r[31 - ((4 * (i / 6) + (i % 6) + 31) % 32)];
    x = e ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      idx = int'({six[5], six[0]}) * 16 + int'(six[4:1]);
      s[31-4*b -: 4] = 4'(SB[b][idx]);
    end
    for (int i = 0; i < 32; i++) o[31-i] = s[32-P_T[i]];
    return o;
  endfunction

  function automatic logic [27:0] rot(input logic [27:0] v,
                                      input logic [1:0] n,
                                      input logic dir);
    int m;
    m = int'(n);
    if (dir) return (v >> m) | (v << (28 - m));
    return (v << m) | (v >> (28 - m));
  endfunction

  logic [63:0] pt_m, key_m, ct_m;
  logic [31:0] l_m, r_m;
  logic [27:0] c_m, d_m;

  // Datapath registers follow unit 0's strobes as a real core would
  always @(negedge clk) begin
    if (load_ip[0]) begin
      {l_m, r_m} = ip_fn(pt_m);
      {c_m, d_m} = pc1_fn(key_m);
    end
    if (round_en[0]) begin
      c_m = rot(c_m, key_rot[0], key_dir[0]);
      d_m = rot(d_m, key_rot[0], key_dir[0]);
      {l_m, r_m} = {r_m, l_m ^ f_fn(r_m, pc2_fn({c_m, d_m}))};
    end
    if (final_en[0]) ct_m = fp_fn({r_m, l_m});
  end

  // ---------------- sequence checking ----------------
  task automatic run_block(input int u, input bit dec,
                           input int inj, input bit b2b);
    int          R;
    bit          dp;
    int          last;
    int          rsum;
    bit          e_rdy, e_bsy, e_ld, e_rnd, e_fin, e_dn;
    logic [1:0]  e_rot;
    logic [3:0]  e_idx;
    logic [12:0] obs, exp;
    R = rounds_of(u);
    dp = dp_of(u);
    last = b2b ? R + 3 : R + 4;
    rsum = 0;
    checks++;
    if (ready[u] !== 1'b1) begin
      failures++;
      $display("FAIL accept_ready u%0d got=%b exp=1", u, ready[u]);
    end
    start[u] = 1'b1;
    dec_i[u] = dec;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      start[u] = 1'b0;
      dec_i[u] = dec;
      e_rdy = (k == R + 3 && !dp) || k == R + 4;
      e_bsy = k <= R + 2;
      e_ld  = k == 1;
      e_rnd = k >= 2 && k <= R + 1;
      e_fin = k == R + 2;
      e_dn  = k == R + 3 || (k == R + 4 && !dp);
      e_idx = e_rnd ? 4'(k - 2) : 4'd0;
      e_rot = e_rnd ? sched(k - 2, dec) : 2'd0;
      rsum += int'(key_rot[u]);
      obs = {ready[u], busy[u], load_ip[u], round_en[u], final_en[u],
             done[u], e_bsy ? key_dir[u] : 1'b0, key_rot[u],
             e_rnd ? round_idx[u] : 4'd0};
      exp = {e_rdy, e_bsy, e_ld, e_rnd, e_fin, e_dn,
             e_bsy ? dec : 1'b0, e_rot, e_idx};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL seq u%0d k%0d got=%b exp=%b", u, k, obs, exp);
      end
      if (k == inj) begin
        start[u] = 1'b1;
        dec_i[u] = ~dec;
      end
    end
    if (R == 16) begin
      checks++;
      if (rsum != (dec ? 27 : 28)) begin
        failures++;
        $display("FAIL rot_sum u%0d got=%0d exp=%0d",
                 u, rsum, dec ? 27 : 28);
      end
    end
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      obs = {ready[u], busy[u], load_ip[u], round_en[u], final_en[u],
             done[u], key_dir[u], key_rot[u], round_idx[u]};
      checks++;
      if (obs !== 13'b1_000_000_00_0000) begin
        failures++;
        $display("FAIL reset u%0d got=%b exp=%b", u, obs,
                 13'b1_000_000_00_0000);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_encrypt();
    run_block(0, 1'b0, 0, 1'b0);
    run_block(2, 1'b0, 0, 1'b0);
  endtask

  task automatic test_decrypt();
    run_block(0, 1'b1, 0, 1'b0);
    run_block(2, 1'b1, 0, 1'b0);
  endtask

  task automatic test_busy_start();
    int nd;
    run_block(0, 1'b0, 5, 1'b0);
    for (int t = 0; t < 4; t++) begin
      run_block(0, 1'(t), int'($urandom_range(2, 19)), 1'b0);
      run_block(2, 1'(t), int'($urandom_range(2, 4)), 1'b0);
    end
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done[0] || done[2]) nd++;
    end
    checks++;
    if (nd != 0) begin
      failures++;
      $display("FAIL extra_done got=%0d exp=0", nd);
    end
  endtask

  task automatic test_done_hold();
    int held;
    run_block(1, 1'b0, 0, 1'b0);
    held = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done[1] === 1'b1 && ready[1] === 1'b1) held++;
    end
    checks++;
    if (held != 3) begin
      failures++;
      $display("FAIL done_hold got=%0d exp=3", held);
    end
    run_block(1, 1'b1, 0, 1'b1);
    run_block(1, 1'b0, 7, 1'b1);
    run_block(1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_golden();
    logic [63:0] p, c;
    pt_m  = 64'h0123456789ABCDEF;
    key_m = 64'h133457799BBCDFF1;
    run_block(0, 1'b0, 0, 1'b0);
    checks++;
    if (ct_m !== 64'h85E813540F0AB405) begin
      failures++;
      $display("FAIL golden_enc got=%h exp=85e813540f0ab405", ct_m);
    end
    pt_m = ct_m;
    run_block(0, 1'b1, 0, 1'b0);
    checks++;
    if (ct_m !== 64'h0123456789ABCDEF) begin
      failures++;
      $display("FAIL golden_dec got=%h exp=0123456789abcdef", ct_m);
    end
    for (int t = 0; t < 3; t++) begin
      p = {$urandom, $urandom};
      key_m = {$urandom, $urandom};
      pt_m = p;
      run_block(0, 1'b0, 0, 1'b0);
      c = ct_m;
      pt_m = c;
      run_block(0, 1'b1, int'($urandom_range(2, 18)), 1'b0);
      checks++;
      if (ct_m !== p) begin
        failures++;
        $display("FAIL roundtrip%0d got=%h exp=%h", t, ct_m, p);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [12:0] obs;
    int          bad;
    start[0] = 1'b1;
    dec_i[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    checks++;
    if (round_en[0] !== 1'b1 || round_idx[0] !== 4'd5) begin
      failures++;
      $display("FAIL pre_reset_idx got=%0d exp=5", round_idx[0]);
    end
    #2 rst = 1'b1;
    #1;
    obs = {ready[0], busy[0], load_ip[0], round_en[0], final_en[0],
           done[0], key_dir[0], key_rot[0], round_idx[0]};
    checks++;
    if (obs !== 13'b1_000_000_00_0000) begin
      failures++;
      $display("FAIL async_reset got=%b exp=%b", obs,
               13'b1_000_000_00_0000);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done[0] !== 1'b0 || ready[0] !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abort_no_done got=%0d exp=0", bad);
    end
  endtask

  task automatic test_random();
    int u;
    bit b2b;
    int inj;
    for (int t = 0; t < 12; t++) begin
      u = int'($urandom_range(0, 2));
      b2b = (u == 1) && ($urandom_range(0, 1) == 1);
      inj = ($urandom_range(0, 1) == 1) ?
            int'($urandom_range(2, rounds_of(u) + 2)) : 0;
      run_block(u, 1'($urandom), inj, b2b);
      if (b2b) run_block(1, 1'($urandom), 0, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    for (int u = 0; u < NU; u++) begin
      start[u] = 1'b0;
      dec_i[u] = 1'b0;
    end
    pt_m = '0;
    key_m = '0;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_busy_start();
    test_done_hold();
    test_golden();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
